// File: rtl/pcihellocore_button_debounce_pkg.sv
// Shared constants and types for the push-button conditioning block.
package pcihellocore_button_debounce_pkg;

    localparam int unsigned ACTIVE_LOW_DEF      = 32'd1;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd1000000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 32'd4;
    localparam int unsigned PRESS_CNT_W         = 32'd8;
    localparam int unsigned OUT_W               = 32'd32;

    typedef logic [PRESS_CNT_W-1:0] press_cnt_t;
    typedef logic [OUT_W-1:0]       out_word_t;

endpackage

// File: rtl/pcihellocore_button_debounce_if.sv
// Button-side signal bundle: raw pins in, conditioned level/events out.
interface pcihellocore_button_debounce_if #(
    parameter int unsigned WIDTH = 32'd4
);
    import pcihellocore_button_debounce_pkg::*;

    logic [WIDTH-1:0] button_raw;
    out_word_t        out_port;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    press_cnt_t       press_count;

    modport master (
        output button_raw,
        input  out_port,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );

    modport slave (
        input  button_raw,
        output out_port,
        output press_pulse,
        output release_pulse,
        output press_count
    );

endinterface

// File: rtl/pcihellocore_button_debounce_bit.sv
// One button: 2-flop synchroniser, stability counter, accepted level and edge pulses.
// The input is already polarity-corrected, so "released" is always 0 here.
module pcihellocore_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Any sample matching the accepted level restarts the stability window.
    always_comb begin
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            stable_d  = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Synchroniser, counter, accepted level and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= pin_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/pcihellocore_button_debounce.sv
// Push-button conditioner: polarity fix, per-bit debounce, PIO level word and press counter.
module pcihellocore_button_debounce
    import pcihellocore_button_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 32'd4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
    input  logic clk,
    input  logic reset_n,
    pcihellocore_button_debounce_if.slave bus
);
    logic [WIDTH-1:0] pin_s;
    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] press_s;
    logic [WIDTH-1:0] release_s;
    out_word_t        out_s;
    press_cnt_t       press_count_q;
    press_cnt_t       press_count_d;

    assign pin_s = (ACTIVE_LOW != 32'd0) ? ~bus.button_raw : bus.button_raw;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin_i    (pin_s[i]),
            .stable_o (stable_s[i]),
            .press_o  (press_s[i]),
            .release_o(release_s[i])
        );
    end

    // Zero-extend the accepted levels; stable_s comes straight from flops.
    always_comb begin
        out_s              = '0;
        out_s[WIDTH-1:0]   = stable_s;
    end

    // One count per pulsing cycle, however many buttons pulse together.
    always_comb begin
        if (|press_s) begin
            press_count_d = press_count_q + 8'd1;
        end else begin
            press_count_d = press_count_q;
        end
    end

    // Wrapping press counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_count_q <= 8'd0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign bus.out_port      = out_s;
    assign bus.press_pulse   = press_s;
    assign bus.release_pulse = release_s;
    assign bus.press_count   = press_count_q;

endmodule

// File: tb/tb_pcihellocore_button_debounce.sv
// Directed bench for the push-button conditioner (4 buttons, 4-cycle debounce, active-low pins).
module tb_pcihellocore_button_debounce;
    import pcihellocore_button_debounce_pkg::*;

    logic clk;
    logic reset_n;
    int   n_total;
    int   n_bad;
    logic [7:0] exp_cnt;

    pcihellocore_button_debounce_if #(.WIDTH(32'd4)) bus ();

    pcihellocore_button_debounce #(
        .WIDTH          (32'd4),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM),
        .ACTIVE_LOW     (32'd1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;

        // 1. reset state, all buttons released
        reset_n        = 1'b0;
        bus.button_raw = 4'hF;
        tick(3);
        check_val("rst_out",   bus.out_port, 32'h0);
        check_val("rst_press", {28'd0, bus.press_pulse}, 32'h0);
        check_val("rst_rel",   {28'd0, bus.release_pulse}, 32'h0);
        check_val("rst_cnt",   {24'd0, bus.press_count}, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_val("idle_out",   bus.out_port, 32'h0);
            check_val("idle_press", {28'd0, bus.press_pulse}, 32'h0);
        end

        // 2. clean press of bit 0, accepted at the 6th edge
        bus.button_raw = 4'hE;
        tick(5);
        check_val("p0_early_out",   bus.out_port, 32'h0);
        check_val("p0_early_press", {28'd0, bus.press_pulse}, 32'h0);
        tick(1);
        check_val("p0_out",   bus.out_port, 32'h1);
        check_val("p0_press", {28'd0, bus.press_pulse}, 32'h1);
        tick(1);
        check_val("p0_press_end", {28'd0, bus.press_pulse}, 32'h0);
        check_val("p0_cnt",       {24'd0, bus.press_count}, 32'd1);

        // 3. bit 1 bounces: 3 cycles low, 1 high, three times
        for (int r = 0; r < 3; r++) begin
            bus.button_raw[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                check_val("bnc_out",   bus.out_port, 32'h1);
                check_val("bnc_press", {28'd0, bus.press_pulse}, 32'h0);
            end
            bus.button_raw[1] = 1'b1;
            tick(1);
            check_val("bnc_out",   bus.out_port, 32'h1);
            check_val("bnc_press", {28'd0, bus.press_pulse}, 32'h0);
        end
        bus.button_raw[1] = 1'b0;
        tick(5);
        check_val("bnc_hold_early", bus.out_port, 32'h1);
        tick(1);
        check_val("bnc_hold_out",   bus.out_port, 32'h3);
        check_val("bnc_hold_press", {28'd0, bus.press_pulse}, 32'h2);
        tick(1);
        check_val("bnc_cnt", {24'd0, bus.press_count}, 32'd2);

        // 4. bits 2 and 3 pressed together
        bus.button_raw = 4'h0;
        tick(5);
        check_val("sim_early", bus.out_port, 32'h3);
        tick(1);
        check_val("sim_out",   bus.out_port, 32'hF);
        check_val("sim_press", {28'd0, bus.press_pulse}, 32'hC);
        tick(1);
        check_val("sim_press_end", {28'd0, bus.press_pulse}, 32'h0);
        check_val("sim_cnt",       {24'd0, bus.press_count}, 32'd3);
        tick(1);
        check_val("sim_cnt_hold",  {24'd0, bus.press_count}, 32'd3);

        // 5. release bit 0, then 256 press/release cycles to wrap the counter
        bus.button_raw = 4'h1;
        tick(5);
        check_val("rel_early", {28'd0, bus.release_pulse}, 32'h0);
        tick(1);
        check_val("rel_pulse", {28'd0, bus.release_pulse}, 32'h1);
        check_val("rel_out",   bus.out_port, 32'hE);
        check_val("rel_press", {28'd0, bus.press_pulse}, 32'h0);
        tick(1);
        check_val("rel_end",   {28'd0, bus.release_pulse}, 32'h0);
        check_val("rel_cnt",   {24'd0, bus.press_count}, 32'd3);

        exp_cnt = 8'd3;
        for (int i = 0; i < 256; i++) begin
            bus.button_raw[0] = 1'b0;
            tick(6);
            bus.button_raw[0] = 1'b1;
            tick(6);
            exp_cnt = exp_cnt + 8'd1;
            check_val("wrap_cnt", {24'd0, bus.press_count}, {24'd0, exp_cnt});
        end
        check_val("wrap_final", {24'd0, bus.press_count}, 32'd3);

        // 6. reset during a debounce, then release reset with buttons held
        bus.button_raw = 4'h0;
        tick(3);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_out",   bus.out_port, 32'h0);
        check_val("mid_rst_press", {28'd0, bus.press_pulse}, 32'h0);
        check_val("mid_rst_cnt",   {24'd0, bus.press_count}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check_val("post_rst_early", bus.out_port, 32'h0);
        check_val("post_rst_nopls", {28'd0, bus.press_pulse}, 32'h0);
        tick(1);
        check_val("post_rst_out",   bus.out_port, 32'hF);
        check_val("post_rst_press", {28'd0, bus.press_pulse}, 32'hF);
        tick(1);
        check_val("post_rst_end",   {28'd0, bus.press_pulse}, 32'h0);
        check_val("post_rst_cnt",   {24'd0, bus.press_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
